// File: rtl/bram_stream_reader_pkg.sv
// Shared stream widths, keep constant and FSM state encoding for the BRAM frame reader.
package bram_stream_reader_pkg;

    localparam int AXIS_DATA_W = 128;
    localparam int AXIS_KEEP_W = 16;
    localparam logic [AXIS_KEEP_W-1:0] KEEP_ALL = 16'hFFFF;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// Synchronous FIFO with exposed count/empty/full and a combinational head.
// Storage is not reset; only pointers and count are.
module stream_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Reads one frame of 128-bit words from BRAM and streams it as an AXI-Stream master.
// Reads are issued only against free FIFO credit, so back-pressure never drops a word.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int IMAGE_DEPTH  = 768,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  bram_addr,
    output logic                   bram_en,
    input  logic [AXIS_DATA_W-1:0] bram_dout,
    output logic [AXIS_DATA_W-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMAGE_DEPTH - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   issue_ptr;
    logic                    issue;
    logic                    issue_last;
    logic                    start_accept;
    logic                    final_beat;
    logic                    credit_ok;
    logic [OCC_W-1:0]        in_flight;
    logic [OCC_W-1:0]        occupancy;

    logic                    en_p0;
    logic                    last_p0;
    logic [READ_LATENCY-1:0] vld_p1;
    logic [READ_LATENCY-1:0] last_p1;

    logic                    push;
    logic                    pop;
    logic [AXIS_DATA_W:0]    fifo_head;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic                    fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)      state_nxt = ST_READ;
            ST_READ:  if (issue_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (final_beat) state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // A word counts against credit from issue until it is popped; a same-cycle pop frees its slot.
    always_comb begin
        in_flight = OCC_W'(en_p0);
        for (int i = 0; i < READ_LATENCY; i++) begin
            in_flight = in_flight + OCC_W'(vld_p1[i]);
        end
    end

    assign occupancy = OCC_W'(fifo_count) + in_flight;
    assign credit_ok = occupancy < (OCC_W'(FIFO_DEPTH) + OCC_W'(pop));

    always_comb begin
        issue        = (state == ST_READ) && credit_ok;
        issue_last   = issue && (issue_ptr == LAST_ADDR);
        start_accept = (state == ST_IDLE) && start;
        final_beat   = (state == ST_DRAIN) && pop && m_axis_tlast;
        busy         = (state != ST_IDLE);
    end

    // Stage p0: registered BRAM request, travels with its frame-last flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_ptr <= '0;
            bram_addr <= '0;
            en_p0     <= 1'b0;
            last_p0   <= 1'b0;
            done      <= 1'b0;
        end else begin
            en_p0   <= issue;
            last_p0 <= issue_last;
            if (issue) bram_addr <= issue_ptr;
            if (start_accept)            issue_ptr <= '0;
            else if (issue && !issue_last) issue_ptr <= issue_ptr + 1'b1;
            if (start_accept)    done <= 1'b0;
            else if (final_beat) done <= 1'b1;
        end
    end

    assign bram_en = en_p0;

    // Stage p1: flags delayed to match BRAM read latency; the last stage aligns with bram_dout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= '0;
            last_p1 <= '0;
        end else begin
            vld_p1[0]  <= en_p0;
            last_p1[0] <= last_p0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p1[i]  <= vld_p1[i-1];
                last_p1[i] <= last_p1[i-1];
            end
        end
    end

    assign push = vld_p1[READ_LATENCY-1] && !fifo_full;
    assign pop  = m_axis_tvalid && m_axis_tready;

    stream_fifo #(
        .WIDTH (AXIS_DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({last_p1[READ_LATENCY-1], bram_dout}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Output: FIFO head, forced to zero when empty so idle/reset shows clean values
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : fifo_head[AXIS_DATA_W-1:0];
    assign m_axis_tlast  = !fifo_empty && fifo_head[AXIS_DATA_W];
    assign m_axis_tkeep  = KEEP_ALL;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: two instances (read latency 1 and 2) share stimulus;
// a scoreboard queue per instance holds the expected frame, a monitor pops on each handshake.
module tb_bram_stream_reader;

    localparam int IMAGE_DEPTH = 768;
    localparam int ADDR_WIDTH  = 10;
    localparam int FIFO_DEPTH  = 4;
    localparam int N           = 2;

    typedef logic [128:0] beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic tready;

    logic                  busy      [N];
    logic                  done      [N];
    logic                  bram_en   [N];
    logic [ADDR_WIDTH-1:0] bram_addr [N];
    logic [127:0]          bram_dout [N];
    logic [127:0]          tdata     [N];
    logic [15:0]           tkeep     [N];
    logic                  tlast     [N];
    logic                  tvalid    [N];
    logic [7:0]            fcount    [N];

    logic [127:0] mem [IMAGE_DEPTH];
    beat_t        exp_q [N][$];

    int n_checks;
    int n_fail;
    int cyc;
    int start_cyc;
    int en_cnt     [N];
    int beats      [N];
    int rise_cyc   [N];
    int last_cyc   [N];
    int base_en    [N];
    int base_beats [N];

    logic         held      [N];
    logic [127:0] held_data [N];
    logic         held_last [N];
    logic         prev_v    [N];
    logic         done_nxt  [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int RL = g + 1;
        logic [127:0] q0;
        logic [127:0] q1;

        bram_stream_reader #(
            .IMAGE_DEPTH  (IMAGE_DEPTH),
            .ADDR_WIDTH   (ADDR_WIDTH),
            .READ_LATENCY (RL),
            .FIFO_DEPTH   (FIFO_DEPTH)
        ) dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .start         (start),
            .busy          (busy[g]),
            .done          (done[g]),
            .bram_addr     (bram_addr[g]),
            .bram_en       (bram_en[g]),
            .bram_dout     (bram_dout[g]),
            .m_axis_tdata  (tdata[g]),
            .m_axis_tkeep  (tkeep[g]),
            .m_axis_tlast  (tlast[g]),
            .m_axis_tvalid (tvalid[g]),
            .m_axis_tready (tready)
        );

        always @(posedge clk) begin
            if (bram_en[g]) q0 <= mem[bram_addr[g]];
            q1 <= q0;
        end

        assign bram_dout[g] = (RL == 1) ? q0 : q1;
        assign fcount[g]    = 8'(dut.u_fifo.count);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (!rst_n) begin
                held[g]     = 1'b0;
                prev_v[g]   = 1'b0;
                done_nxt[g] = 1'b0;
            end else begin
                if (done_nxt[g]) begin
                    check($sformatf("d%0d_done_after_last", g), 128'(done[g]), 128'(1));
                    check($sformatf("d%0d_busy_after_last", g), 128'(busy[g]), 128'(0));
                    done_nxt[g] = 1'b0;
                end
                if (bram_en[g]) en_cnt[g]++;
                check($sformatf("d%0d_fifo_bound", g), 128'(fcount[g] <= 8'(FIFO_DEPTH)), 128'(1));
                if (held[g]) begin
                    check($sformatf("d%0d_stall_valid", g), 128'(tvalid[g]), 128'(1));
                    check($sformatf("d%0d_stall_data", g), tdata[g], held_data[g]);
                    check($sformatf("d%0d_stall_last", g), 128'(tlast[g]), 128'(held_last[g]));
                end
                if (tvalid[g] && !prev_v[g]) rise_cyc[g] = cyc;
                if (tvalid[g]) check($sformatf("d%0d_tkeep", g), 128'(tkeep[g]), 128'(16'hFFFF));
                if (tvalid[g] && tready) begin
                    if (exp_q[g].size() == 0) begin
                        check($sformatf("d%0d_unexpected_beat", g), 128'(1), 128'(0));
                    end else begin
                        beat_t e;
                        e = exp_q[g].pop_front();
                        check($sformatf("d%0d_data", g), tdata[g], e[127:0]);
                        check($sformatf("d%0d_last", g), 128'(tlast[g]), 128'(e[128]));
                    end
                    beats[g]++;
                    if (tlast[g]) begin
                        last_cyc[g] = cyc;
                        done_nxt[g] = 1'b1;
                    end
                    held[g] = 1'b0;
                end else if (tvalid[g]) begin
                    held[g]      = 1'b1;
                    held_data[g] = tdata[g];
                    held_last[g] = tlast[g];
                end else begin
                    held[g] = 1'b0;
                end
                prev_v[g] = tvalid[g];
            end
        end
    end

    task automatic check_reset(input string tag);
        for (int g = 0; g < N; g++) begin
            check($sformatf("%s_d%0d_busy", tag, g), 128'(busy[g]), 128'(0));
            check($sformatf("%s_d%0d_done", tag, g), 128'(done[g]), 128'(0));
            check($sformatf("%s_d%0d_bram_en", tag, g), 128'(bram_en[g]), 128'(0));
            check($sformatf("%s_d%0d_bram_addr", tag, g), 128'(bram_addr[g]), 128'(0));
            check($sformatf("%s_d%0d_tvalid", tag, g), 128'(tvalid[g]), 128'(0));
            check($sformatf("%s_d%0d_tlast", tag, g), 128'(tlast[g]), 128'(0));
            check($sformatf("%s_d%0d_tdata", tag, g), tdata[g], 128'(0));
        end
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        for (int g = 0; g < N; g++) begin
            base_en[g]    = en_cnt[g];
            base_beats[g] = beats[g];
            check($sformatf("start_d%0d_busy", g), 128'(busy[g]), 128'(1));
            check($sformatf("start_d%0d_done_clear", g), 128'(done[g]), 128'(0));
            for (int i = 0; i < IMAGE_DEPTH; i++) begin
                exp_q[g].push_back({(i == IMAGE_DEPTH - 1), mem[i]});
            end
        end
    endtask

    task automatic wait_done(input bit rnd, input bit pulse, input string tag);
        int n;
        n = 0;
        while (!(done[0] && done[1]) && n < 20000) begin
            @(posedge clk); #1;
            start = pulse && busy[0] && busy[1] && ($urandom_range(0, 31) == 0);
            if (rnd) tready = 1'($urandom_range(0, 1));
            n++;
        end
        start = 1'b0;
        check({tag, "_timeout"}, 128'(n < 20000), 128'(1));
        for (int g = 0; g < N; g++) begin
            check($sformatf("%s_d%0d_missing", tag, g), 128'(exp_q[g].size()), 128'(0));
            check($sformatf("%s_d%0d_beats", tag, g), 128'(beats[g] - base_beats[g]), 128'(IMAGE_DEPTH));
        end
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < IMAGE_DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        start  = 1'b0;
        tready = 1'b0;
        for (int i = 0; i < IMAGE_DEPTH; i++) mem[i] = 128'(i);
        repeat (3) @(posedge clk); #1;
        check_reset("por");
        rst_n = 1'b1;

        // Ordered ramp, tready always high: latency and gap-free throughput
        tready = 1'b1;
        start_frame();
        wait_done(1'b0, 1'b0, "ramp");
        for (int g = 0; g < N; g++) begin
            check($sformatf("ramp_d%0d_first_latency", g), 128'(rise_cyc[g] - start_cyc), 128'(g + 3));
            check($sformatf("ramp_d%0d_no_bubbles", g), 128'(last_cyc[g] - rise_cyc[g]), 128'(IMAGE_DEPTH - 1));
        end

        // Random data, random back-pressure, stray starts while busy
        randomize_mem();
        start_frame();
        wait_done(1'b1, 1'b1, "random");

        // Second frame after done must be identical
        start_frame();
        wait_done(1'b1, 1'b1, "repeat");

        // Held-off sink: reads stop at FIFO_DEPTH, stream resumes at word 0
        tready = 1'b0;
        start_frame();
        repeat (20) @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            check($sformatf("stall_d%0d_reads", g), 128'(en_cnt[g] - base_en[g]), 128'(FIFO_DEPTH));
            check($sformatf("stall_d%0d_tvalid", g), 128'(tvalid[g]), 128'(1));
            check($sformatf("stall_d%0d_word0", g), tdata[g], mem[0]);
        end
        tready = 1'b1;
        wait_done(1'b0, 1'b0, "stall");

        // Reset in the middle of a frame, then a complete restart
        randomize_mem();
        start_frame();
        n = 0;
        while ((beats[0] - base_beats[0]) < 300 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("midreset_reach_300", 128'(n < 5000), 128'(1));
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        for (int g = 0; g < N; g++) exp_q[g].delete();
        repeat (3) @(posedge clk);
        #1;
        check_reset("heldreset");
        rst_n = 1'b1;
        start_frame();
        wait_done(1'b0, 1'b0, "restart");
        for (int g = 0; g < N; g++) begin
            check($sformatf("restart_d%0d_no_bubbles", g), 128'(last_cyc[g] - rise_cyc[g]), 128'(IMAGE_DEPTH - 1));
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
